// File: rtl/uart_frame_rx_pkg.sv
// Purpose: shared state encodings, error codes and sizing helper for the framed UART receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_HUNT0 = 3'd0,
        ST_HUNT1 = 3'd1,
        ST_CMD   = 3'd2,
        ST_LEN   = 3'd3,
        ST_DATA  = 3'd4,
        ST_CHK   = 3'd5,
        ST_DRAIN = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
    localparam logic [7:0] HDR1_DEFAULT = 8'h55;

    // Address width for a buffer of the given depth; never zero.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Purpose: MAX_LEN x 8 payload store, one write port and one registered read port.
// Latency: write lands at the clock edge; read data appears the cycle after rd_en.
// Backpressure: none; rd_data holds its value while rd_en is low.
// Ports: clk_50m/rst clock and sync reset; wr_en/wr_addr/wr_data write port;
//        rd_en/rd_addr read request; rd_data registered read result (0 after reset).
module uart_frame_buf
    import uart_frame_rx_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int AW      = addr_bits(MAX_LEN)
) (
    input  logic          clk_50m,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [MAX_LEN];

    // Storage itself needs no reset: nothing is read before it has been written.
    always_ff @(posedge clk_50m) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Purpose: parse 0xAA 0x55 CMD LEN PAYLOAD CHK frames from the UART byte receiver, release payload only if checksum is good.
// Latency: frm_ok/frm_err one cycle after the deciding byte is accepted; first payload beat one cycle after frm_ok.
// Backpressure: out_ready stalls the payload stream; while draining no UART bytes are acknowledged, so UART_RX holds its byte.
// Ports: clk_50m/rst clock and sync active-high reset; rx_rdy/rx_data/rx_rdy_clr UART_RX byte handshake;
//        frm_cmd/frm_len/frm_ok/frm_err/err_code frame status; out_valid/out_data/out_last/out_ready payload stream.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] HDR0        = HDR0_DEFAULT,
    parameter logic [7:0] HDR1        = HDR1_DEFAULT,
    parameter int         TIMEOUT_CYC = 500000
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_rdy_clr,
    output logic [7:0] frm_cmd,
    output logic [7:0] frm_len,
    output logic       frm_ok,
    output logic       frm_err,
    output logic [1:0] err_code,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready
);

    localparam int AW = addr_bits(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    guard_q, guard_d;
    logic          ok_d, err_d, vld_d, last_d;
    logic [1:0]    code_d;
    logic          accept, wr_en, rd_en;

    // UART_RX drops rdy a couple of cycles after the clear, so the guard
    // blocks a second accept of the same byte for two cycles.
    assign accept  = rx_rdy && (guard_q == 2'd0) && (state_q != ST_DRAIN);
    assign guard_d = accept ? 2'd2 : ((guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0);

    assign frm_cmd = cmd_q;
    assign frm_len = len_q;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        len_d    = len_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        rd_ptr_d = rd_ptr_q;
        tmo_d    = tmo_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = ERR_NONE;
        vld_d    = out_valid;
        last_d   = out_last;
        wr_en    = 1'b0;
        rd_en    = 1'b0;

        if (accept) begin
            tmo_d = '0;
            unique case (state_q)
                ST_HUNT0: begin
                    if (rx_data == HDR0) state_d = ST_HUNT1;
                end
                ST_HUNT1: begin
                    if (rx_data == HDR1)      state_d = ST_CMD;
                    else if (rx_data == HDR0) state_d = ST_HUNT1;
                    else                      state_d = ST_HUNT0;
                end
                ST_CMD: begin
                    cmd_d   = rx_data;
                    sum_d   = rx_data;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    if (rx_data > 8'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = ST_HUNT0;
                    end else begin
                        len_d   = rx_data;
                        sum_d   = sum_q + rx_data;
                        idx_d   = 8'd0;
                        state_d = (rx_data == 8'd0) ? ST_CHK : ST_DATA;
                    end
                end
                ST_DATA: begin
                    wr_en = 1'b1;
                    sum_d = sum_q + rx_data;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) state_d = ST_CHK;
                end
                ST_CHK: begin
                    if (rx_data == sum_q) begin
                        ok_d     = 1'b1;
                        rd_ptr_d = 8'd0;
                        state_d  = (len_q == 8'd0) ? ST_HUNT0 : ST_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = ST_HUNT0;
                    end
                end
                default: ;
            endcase
        end else if (state_q inside {ST_HUNT1, ST_CMD, ST_LEN, ST_DATA, ST_CHK}) begin
            // A stalled sync pair is simply dropped; inside a frame it is an error.
            if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                state_d = ST_HUNT0;
                if (state_q != ST_HUNT1) begin
                    err_d  = 1'b1;
                    code_d = ERR_TMO;
                end
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        // Drain: the first DRAIN cycle (out_valid still low) prefetches beat 0;
        // afterwards each handshake fetches the next beat, so out_data holds during stalls.
        if (state_q == ST_DRAIN) begin
            if (!out_valid) begin
                rd_en    = 1'b1;
                rd_ptr_d = rd_ptr_q + 8'd1;
                vld_d    = 1'b1;
                last_d   = (rd_ptr_q == len_q - 8'd1);
            end else if (out_ready) begin
                if (out_last) begin
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = ST_HUNT0;
                end else begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 8'd1;
                    last_d   = (rd_ptr_q == len_q - 8'd1);
                end
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q    <= ST_HUNT0;
            cmd_q      <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            rd_ptr_q   <= '0;
            tmo_q      <= '0;
            guard_q    <= '0;
            rx_rdy_clr <= 1'b0;
            frm_ok     <= 1'b0;
            frm_err    <= 1'b0;
            err_code   <= ERR_NONE;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            rd_ptr_q   <= rd_ptr_d;
            tmo_q      <= tmo_d;
            guard_q    <= guard_d;
            rx_rdy_clr <= accept;
            frm_ok     <= ok_d;
            frm_err    <= err_d;
            err_code   <= code_d;
            out_valid  <= vld_d;
            out_last   <= last_d;
        end
    end

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk_50m (clk_50m),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (idx_q[AW-1:0]),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (out_data)
    );

endmodule
